cdc_2phase_channel: RTL and testbench

Single-entry data channel that moves one word from a source port to a destination port with a 2-phase (toggle) req/ack handshake. Req and ack each cross through a multi-stage flop synchronizer chain. The block is the pointer-transport primitive beneath the 2-phase CDC FIFO, and is also usable standalone for low-rate word transfer. All logic runs on one clock, and the synchronizer latency is kept cycle-exact so that the handshake protocol is verifiable.

---
 rtl/cdc_2phase_pkg.sv | 5 +
 rtl/sync_chain.sv | 36 +++
 rtl/cdc_2phase_channel.sv | 117 +++++++++++
 tb/tb_cdc_2phase_channel.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_pkg.sv
// Shared constants and types for the 2-phase toggle handshake channel.
package cdc_2phase_pkg;
   localparam int unsigned DefaultSyncStages = 2;
   typedef logic toggle_t;
endpackage

// File: rtl/sync_chain.sv
// SYNC_STAGES-deep flop shift register for one toggle bit; latency SYNC_STAGES cycles.
// No backpressure: samples d_i every cycle; rst_i and clr_i both zero the chain.
module sync_chain
   import cdc_2phase_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    clr_i,
   input  toggle_t d_i,
   output toggle_t q_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;

   always_comb begin
      chain_d    = chain_q;
      chain_d[0] = d_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_2phase_channel.sv
// Single-word toggle req/ack channel; forward SYNC_STAGES+1 cycles, return SYNC_STAGES cycles.
// One word in flight: src_ready_o low until ack returns. CDC_2PHASE_ASSERTS_EN adds sim checks.
module cdc_2phase_channel
   import cdc_2phase_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  src_clr_i,
   input  logic [DATA_WIDTH-1:0] src_data_i,
   input  logic                  src_valid_i,
   output logic                  src_ready_o,
   input  logic                  dst_clr_i,
   output logic [DATA_WIDTH-1:0] dst_data_o,
   output logic                  dst_valid_o,
   input  logic                  dst_ready_i
);

   toggle_t               req_src_q, req_src_d;
   logic [DATA_WIDTH-1:0] data_src_q, data_src_d;
   toggle_t               dst_req_q, dst_req_d;
   toggle_t               ack_dst_q, ack_dst_d;
   logic [DATA_WIDTH-1:0] data_dst_q, data_dst_d;
   toggle_t               req_sync_last;
   toggle_t               ack_sync_last;
   logic                  accept;
   logic                  pop;

   // The req chain belongs to the destination side, the ack chain to the source side.
   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (dst_clr_i),
      .d_i   (req_src_q),
      .q_o   (req_sync_last)
   );

   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (src_clr_i),
      .d_i   (ack_dst_q),
      .q_o   (ack_sync_last)
   );

   assign src_ready_o = (req_src_q == ack_sync_last);
   assign accept      = src_valid_i && src_ready_o;
   assign dst_valid_o = (dst_req_q != ack_dst_q);
   assign dst_data_o  = data_dst_q;
   assign pop         = dst_valid_o && dst_ready_i;

   always_comb begin
      req_src_d  = req_src_q;
      data_src_d = data_src_q;
      if (accept) begin
         req_src_d  = ~req_src_q;
         data_src_d = src_data_i;
      end
   end

   // data_src_q has been stable for SYNC_STAGES+ cycles by the time the req edge lands here.
   always_comb begin
      dst_req_d  = dst_req_q;
      data_dst_d = data_dst_q;
      ack_dst_d  = ack_dst_q;
      if (req_sync_last != dst_req_q) begin
         dst_req_d  = req_sync_last;
         data_dst_d = data_src_q;
      end
      if (pop) begin
         ack_dst_d = ~ack_dst_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || src_clr_i) begin
         req_src_q  <= 1'b0;
         data_src_q <= '0;
      end else begin
         req_src_q  <= req_src_d;
         data_src_q <= data_src_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || dst_clr_i) begin
         dst_req_q  <= 1'b0;
         ack_dst_q  <= 1'b0;
         data_dst_q <= '0;
      end else begin
         dst_req_q  <= dst_req_d;
         ack_dst_q  <= ack_dst_d;
         data_dst_q <= data_dst_d;
      end
   end

`ifdef CDC_2PHASE_ASSERTS_EN
   if (SYNC_STAGES < 1) begin : g_bad_stages
      $error("cdc_2phase_channel: SYNC_STAGES must be >= 1");
   end

   a_dst_valid_hold : assert property (@(posedge clk_i) disable iff (rst_i || src_clr_i || dst_clr_i)
      (dst_valid_o && !dst_ready_i) |=> dst_valid_o)
      else $error("dst_valid_o fell without a pop");

   a_dst_data_hold : assert property (@(posedge clk_i) disable iff (rst_i || src_clr_i || dst_clr_i)
      (dst_valid_o && !dst_ready_i) |=> $stable(dst_data_o))
      else $error("dst_data_o changed while held");

   a_src_ready_hold : assert property (@(posedge clk_i) disable iff (rst_i || src_clr_i || dst_clr_i)
      (src_ready_o && !src_valid_i) |=> src_ready_o)
      else $error("src_ready_o fell without an accept");
`endif

endmodule

// File: tb/tb_cdc_2phase_channel.sv
module tb_cdc_2phase_channel;

   logic        clk = 1'b0;
   logic        rst;
   logic        src_clr, dst_clr;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] dst_data;
   logic        dst_valid;
   logic        dst_ready;

   logic [31:0] src_data3;
   logic        src_valid3;
   logic        src_ready3;
   logic [31:0] dst_data3;
   logic        dst_valid3;
   logic        dst_ready3;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cdc_2phase_channel #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_clr_i   (src_clr),
      .src_data_i  (src_data),
      .src_valid_i (src_valid),
      .src_ready_o (src_ready),
      .dst_clr_i   (dst_clr),
      .dst_data_o  (dst_data),
      .dst_valid_o (dst_valid),
      .dst_ready_i (dst_ready)
   );

   cdc_2phase_channel #(.DATA_WIDTH(32), .SYNC_STAGES(3)) dut3 (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_clr_i   (1'b0),
      .src_data_i  (src_data3),
      .src_valid_i (src_valid3),
      .src_ready_o (src_ready3),
      .dst_clr_i   (1'b0),
      .dst_data_o  (dst_data3),
      .dst_valid_o (dst_valid3),
      .dst_ready_i (dst_ready3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if (src_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_src_ready: got %b expected 1", src_ready);
      end
      vectors++;
      if (dst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_dst_valid: got %b expected 0", dst_valid);
      end
      vectors++;
      if (dst_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_dst_data: got %h expected 00000000", dst_data);
      end
      vectors++;
      if (src_ready3 !== 1'b1 || dst_valid3 !== 1'b0 || dst_data3 !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_n3: got rdy=%b vld=%b dat=%h expected 1 0 0", src_ready3, dst_valid3, dst_data3);
      end
   endtask

   // Accept at edge 0: valid after edge 3, pop at edge 4, ready back after edge 6.
   task automatic test_single();
      src_data  = 32'hDEADBEEF;
      src_valid = 1'b1;
      dst_ready = 1'b1;
      tick();
      src_valid = 1'b0;
      src_data  = 32'h0;
      for (int e = 0; e <= 6; e++) begin
         if (e > 0) tick();
         vectors++;
         if (dst_valid !== (e == 3) || src_ready !== (e >= 6)) begin
            miscompares++;
            $display("FAIL single_edge%0d: got vld=%b rdy=%b expected vld=%b rdy=%b",
                     e, dst_valid, src_ready, (e == 3), (e >= 6));
         end
         if (e == 3) begin
            vectors++;
            if (dst_data !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL single_data: got %h expected deadbeef", dst_data);
            end
         end
      end
   endtask

   task automatic test_stream();
      int tx = 0;
      int rx = 0;
      int cyc = 0;
      int last_acc = 0;
      logic acc, pp;
      src_data  = 32'd0;
      src_valid = 1'b1;
      dst_ready = 1'b1;
      while (rx < 8 && cyc < 200) begin
         acc = src_valid && src_ready;
         pp  = dst_valid && dst_ready;
         if (pp) begin
            vectors++;
            if (dst_data !== 32'(rx)) begin
               miscompares++;
               $display("FAIL stream_data%0d: got %h expected %h", rx, dst_data, 32'(rx));
            end
            rx++;
         end
         tick();
         cyc++;
         if (acc) begin
            if (tx > 0) begin
               vectors++;
               if (cyc - last_acc != 7) begin
                  miscompares++;
                  $display("FAIL stream_period%0d: got %0d expected 7", tx, cyc - last_acc);
               end
            end
            last_acc = cyc;
            tx++;
            if (tx < 8) src_data = 32'(tx);
            else src_valid = 1'b0;
         end
      end
      vectors++;
      if (rx != 8 || tx != 8) begin
         miscompares++;
         $display("FAIL stream_count: got tx=%0d rx=%0d expected 8 8", tx, rx);
      end
      src_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      src_data  = 32'hA5A51234;
      src_valid = 1'b1;
      dst_ready = 1'b0;
      tick();
      src_valid = 1'b0;
      src_data  = 32'hFFFFFFFF;
      tick();
      tick();
      tick();
      for (int c = 0; c < 20; c++) begin
         vectors++;
         if (dst_valid !== 1'b1 || dst_data !== 32'hA5A51234 || src_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got vld=%b dat=%h rdy=%b expected 1 a5a51234 0",
                     c, dst_valid, dst_data, src_ready);
         end
         tick();
      end
      dst_ready = 1'b1;
      tick();
      for (int j = 0; j <= 2; j++) begin
         if (j > 0) tick();
         vectors++;
         if (dst_valid !== 1'b0 || src_ready !== (j == 2)) begin
            miscompares++;
            $display("FAIL bp_release%0d: got vld=%b rdy=%b expected 0 %b", j, dst_valid, src_ready, (j == 2));
         end
      end
   endtask

   task automatic test_mid_reset();
      int waited = 0;
      src_data  = 32'h00000077;
      src_valid = 1'b1;
      dst_ready = 1'b1;
      tick();
      src_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (src_ready !== 1'b1 || dst_valid !== 1'b0 || dst_data !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_values: got rdy=%b vld=%b dat=%h expected 1 0 0", src_ready, dst_valid, dst_data);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         vectors++;
         if (dst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_ghost%0d: got vld=%b expected 0", c, dst_valid);
         end
      end
      src_data  = 32'h0000005A;
      src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
      dst_ready = 1'b0;
      while (dst_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      vectors++;
      if (waited != 3 || dst_data !== 32'h0000005A) begin
         miscompares++;
         $display("FAIL midrst_next: got lat=%0d dat=%h expected 3 0000005a", waited, dst_data);
      end
      dst_ready = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_clear();
      src_data  = 32'h00000099;
      src_valid = 1'b1;
      dst_ready = 1'b1;
      tick();
      src_valid = 1'b0;
      tick();
      src_clr = 1'b1;
      dst_clr = 1'b1;
      tick();
      src_clr = 1'b0;
      dst_clr = 1'b0;
      for (int c = 0; c < 6; c++) begin
         vectors++;
         if (src_ready !== 1'b1 || dst_valid !== 1'b0 || dst_data !== 32'h0) begin
            miscompares++;
            $display("FAIL clear%0d: got rdy=%b vld=%b dat=%h expected 1 0 0", c, src_ready, dst_valid, dst_data);
         end
         tick();
      end
   endtask

   task automatic test_sync3();
      src_data3  = 32'h00000033;
      src_valid3 = 1'b1;
      dst_ready3 = 1'b0;
      tick();
      src_valid3 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         vectors++;
         if (dst_valid3 !== (e == 4) || src_ready3 !== 1'b0) begin
            miscompares++;
            $display("FAIL n3_fwd_edge%0d: got vld=%b rdy=%b expected %b 0", e, dst_valid3, src_ready3, (e == 4));
         end
      end
      vectors++;
      if (dst_data3 !== 32'h00000033) begin
         miscompares++;
         $display("FAIL n3_data: got %h expected 00000033", dst_data3);
      end
      dst_ready3 = 1'b1;
      tick();
      dst_ready3 = 1'b0;
      for (int j = 0; j <= 3; j++) begin
         if (j > 0) tick();
         vectors++;
         if (src_ready3 !== (j == 3) || dst_valid3 !== 1'b0) begin
            miscompares++;
            $display("FAIL n3_ret%0d: got rdy=%b vld=%b expected %b 0", j, src_ready3, dst_valid3, (j == 3));
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      src_clr    = 1'b0;
      dst_clr    = 1'b0;
      src_data   = 32'h0;
      src_valid  = 1'b0;
      dst_ready  = 1'b0;
      src_data3  = 32'h0;
      src_valid3 = 1'b0;
      dst_ready3 = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_mid_reset();
      test_clear();
      test_sync3();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
